// File: rtl/sd_decimator.sv
// sd_decimator: sinc^2 CIC decoder, 1-bit density stream -> 8-bit PCM.
// clk/rst_n; din+din_valid in; sample (held) + sample_valid (1-cycle pulse) out.
module sd_decimator #(
  parameter int DEC_LOG2 = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  output logic [7:0] sample,
  output logic       sample_valid
);

  localparam int W  = 2 * DEC_LOG2 + 1;
  localparam int SH = 2 * DEC_LOG2 - 8;
  localparam logic [DEC_LOG2-1:0] LAST = '1;
  localparam logic [DEC_LOG2-1:0] ONE  =
    {{(DEC_LOG2-1){1'b0}}, 1'b1};

  logic [W-1:0]        i1, i2, i2_prev, c1_prev;
  logic [W-1:0]        i1_nx, i2_nx, c1, c2, c2_sh;
  logic [DEC_LOG2-1:0] cnt;
  logic                dec_stb;
  logic                warm;
  logic [7:0]          pcm;

  always_comb begin
    i1_nx = i1 + {{(W-1){1'b0}}, din};
    i2_nx = i2 + i1_nx;
    c1    = i2 - i2_prev;
    c2    = c1 - c1_prev;
    c2_sh = c2 >> SH;
    // only full scale (R^2 -> 256) can reach bit 8
    if (|c2_sh[W-1:8]) begin
      pcm = 8'hff;
    end else begin
      pcm = c2_sh[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1           <= '0;
      i2           <= '0;
      i2_prev      <= '0;
      c1_prev      <= '0;
      cnt          <= '0;
      dec_stb      <= 1'b0;
      warm         <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      dec_stb      <= 1'b0;
      if (din_valid) begin
        i1      <= i1_nx;
        i2      <= i2_nx;
        cnt     <= cnt + ONE;
        dec_stb <= (cnt == LAST);
      end
      // comb reads I2 from before this edge; a bit
      // accepted now belongs to the next window
      if (dec_stb) begin
        i2_prev <= i2;
        c1_prev <= c1;
        warm    <= 1'b1;
        if (warm) begin
          sample       <= pcm;
          sample_valid <= 1'b1;
        end
      end
    end
  end

endmodule
